// File: rtl/apb_rr_arbiter.sv
// Two-requester APB arbiter: round-robin grant onto a single downstream APB
// port, one transfer in flight, with an optional ACCESS-phase timeout.
module apb_rr_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,

    input  logic                 S0_PSEL,
    input  logic                 S0_PENABLE,
    input  logic [ADDRWIDTH-1:0] S0_PADDR,
    input  logic                 S0_PWRITE,
    input  logic [31:0]          S0_PWDATA,
    input  logic [3:0]           S0_PSTRB,
    input  logic [2:0]           S0_PPROT,
    output logic [31:0]          S0_PRDATA,
    output logic                 S0_PREADY,
    output logic                 S0_PSLVERR,

    input  logic                 S1_PSEL,
    input  logic                 S1_PENABLE,
    input  logic [ADDRWIDTH-1:0] S1_PADDR,
    input  logic                 S1_PWRITE,
    input  logic [31:0]          S1_PWDATA,
    input  logic [3:0]           S1_PSTRB,
    input  logic [2:0]           S1_PPROT,
    output logic [31:0]          S1_PRDATA,
    output logic                 S1_PREADY,
    output logic                 S1_PSLVERR,

    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,

    output logic [1:0]           GNT
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    logic [1:0]           state;
    logic                 last_s1;
    logic [1:0]           gnt;
    logic [7:0]           cnt;

    logic [ADDRWIDTH-1:0] addr_p0;
    logic                 write_p0;
    logic [31:0]          wdata_p0;
    logic [3:0]           strb_p0;
    logic [2:0]           prot_p0;

    logic [1:0]           req;
    logic [1:0]           pick;
    logic                 in_access;
    logic                 done;
    logic                 expired;
    logic                 finish;
    logic                 rsp_vld;
    logic                 rsp_err;
    logic [31:0]          rsp_rdata;
    logic                 unused_penable;

    // On a tie the requester that was not served last wins; a sole requester always wins.
    function automatic logic [1:0] pick_grant(input logic [1:0] r, input logic last_was_s1);
        logic [1:0] g;
        case (r)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last_was_s1 ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    assign req            = {S1_PSEL, S0_PSEL};
    assign pick           = pick_grant(req, last_s1);
    assign unused_penable = S0_PENABLE ^ S1_PENABLE;

    assign in_access = (state == ACCESS);
    assign done      = in_access && PREADY;
    assign expired   = TO_EN && in_access && !PREADY && (cnt == TO_LAST);
    assign finish    = done || expired;

    // ---- request capture / transfer sequencing (stage p0) ----
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= IDLE;
            last_s1  <= 1'b1;
            gnt      <= 2'b00;
            cnt      <= 8'd0;
            addr_p0  <= '0;
            write_p0 <= 1'b0;
            wdata_p0 <= 32'd0;
            strb_p0  <= 4'd0;
            prot_p0  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= pick;
                        addr_p0  <= pick[1] ? S1_PADDR  : S0_PADDR;
                        write_p0 <= pick[1] ? S1_PWRITE : S0_PWRITE;
                        wdata_p0 <= pick[1] ? S1_PWDATA : S0_PWDATA;
                        strb_p0  <= pick[1] ? S1_PSTRB  : S0_PSTRB;
                        prot_p0  <= pick[1] ? S1_PPROT  : S0_PPROT;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= 8'd0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        last_s1 <= gnt[1];
                        gnt     <= 2'b00;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---- downstream drive and requester response ----
    // Everything is forced low while HRESET is high so a transfer abandoned by
    // reset never leaks a ready pulse back to its requester.
    assign PSEL    = !HRESET && (state != IDLE);
    assign PENABLE = !HRESET && in_access;
    assign PWRITE  = !HRESET && write_p0;
    assign PADDR   = HRESET ? '0     : addr_p0;
    assign PWDATA  = HRESET ? 32'd0  : wdata_p0;
    assign PSTRB   = HRESET ? 4'd0   : strb_p0;
    assign PPROT   = HRESET ? 3'd0   : prot_p0;
    assign GNT     = HRESET ? 2'b00  : gnt;

    assign rsp_vld   = !HRESET && finish;
    assign rsp_err   = PREADY ? PSLVERR : 1'b1;
    assign rsp_rdata = PREADY ? PRDATA  : 32'd0;

    assign S0_PREADY  = rsp_vld && gnt[0];
    assign S0_PSLVERR = rsp_vld && gnt[0] && rsp_err;
    assign S0_PRDATA  = (rsp_vld && gnt[0]) ? rsp_rdata : 32'd0;

    assign S1_PREADY  = rsp_vld && gnt[1];
    assign S1_PSLVERR = rsp_vld && gnt[1] && rsp_err;
    assign S1_PRDATA  = (rsp_vld && gnt[1]) ? rsp_rdata : 32'd0;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter (TIMEOUT=4): fixed cycle-by-cycle
// stimulus with hand-derived expected values and a tiny write-capture slave.
module tb_apb_rr_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        S0_PSEL, S0_PENABLE, S0_PWRITE;
    logic [31:0] S0_PADDR, S0_PWDATA;
    logic [3:0]  S0_PSTRB;
    logic [2:0]  S0_PPROT;
    logic [31:0] S0_PRDATA;
    logic        S0_PREADY, S0_PSLVERR;
    logic        S1_PSEL, S1_PENABLE, S1_PWRITE;
    logic [31:0] S1_PADDR, S1_PWDATA;
    logic [3:0]  S1_PSTRB;
    logic [2:0]  S1_PPROT;
    logic [31:0] S1_PRDATA;
    logic        S1_PREADY, S1_PSLVERR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [1:0]  GNT;

    logic [31:0] mem [0:255];
    int          n_checks = 0;
    int          n_errors = 0;

    apb_rr_arbiter #(.ADDRWIDTH(32), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .S0_PSEL(S0_PSEL), .S0_PENABLE(S0_PENABLE), .S0_PADDR(S0_PADDR),
        .S0_PWRITE(S0_PWRITE), .S0_PWDATA(S0_PWDATA), .S0_PSTRB(S0_PSTRB),
        .S0_PPROT(S0_PPROT), .S0_PRDATA(S0_PRDATA), .S0_PREADY(S0_PREADY),
        .S0_PSLVERR(S0_PSLVERR),
        .S1_PSEL(S1_PSEL), .S1_PENABLE(S1_PENABLE), .S1_PADDR(S1_PADDR),
        .S1_PWRITE(S1_PWRITE), .S1_PWDATA(S1_PWDATA), .S1_PSTRB(S1_PSTRB),
        .S1_PPROT(S1_PPROT), .S1_PRDATA(S1_PRDATA), .S1_PREADY(S1_PREADY),
        .S1_PSLVERR(S1_PSLVERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .GNT(GNT)
    );

    always #5 HCLK = ~HCLK;

    // Slave side: commit completed writes mid-cycle, well away from the active edge.
    always @(negedge HCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE)
            mem[PADDR[7:0]] = PWDATA;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    logic [1:0] rr_gnt [0:12];
    logic [1:0] rr_rdy [0:12];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rr_gnt = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                   2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        rr_rdy = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                   2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

        HRESET = 1'b1;
        S0_PSEL = 0; S0_PENABLE = 0; S0_PWRITE = 0; S0_PADDR = 0; S0_PWDATA = 0;
        S0_PSTRB = 0; S0_PPROT = 0;
        S1_PSEL = 0; S1_PENABLE = 0; S1_PWRITE = 0; S1_PADDR = 0; S1_PWDATA = 0;
        S1_PSTRB = 0; S1_PPROT = 0;
        PRDATA = 0; PREADY = 0; PSLVERR = 0;

        // Reset: every output low
        cyc(); cyc(); #1;
        check("rst_psel",    PSEL,       0);
        check("rst_penable", PENABLE,    0);
        check("rst_gnt",     GNT,        0);
        check("rst_paddr",   PADDR,      0);
        check("rst_pwdata",  PWDATA,     0);
        check("rst_ctl",     {PWRITE, PSTRB, PPROT}, 0);
        check("rst_rsp",     {S0_PREADY, S0_PSLVERR, S1_PREADY, S1_PSLVERR}, 0);
        check("rst_rdata",   {S0_PRDATA, S1_PRDATA}, 0);
        HRESET = 1'b0;
        cyc(); #1;
        check("idle_psel", PSEL, 0);
        check("idle_gnt",  GNT,  0);

        // Round-robin: both request continuously, S0 wins the first tie
        PREADY = 1'b1; PRDATA = 32'hCAFE0000;
        cyc();
        S0_PSEL = 1; S0_PADDR = 32'h40;
        S1_PSEL = 1; S1_PADDR = 32'h44;
        #1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                cyc(); #1;
            end
            check($sformatf("rr_gnt%0d", i),  GNT, rr_gnt[i]);
            check($sformatf("rr_psel%0d", i), PSEL, rr_gnt[i] != 2'b00);
            check($sformatf("rr_rdy%0d", i),  {S1_PREADY, S0_PREADY}, rr_rdy[i]);
            if (rr_gnt[i] != 2'b00)
                check($sformatf("rr_addr%0d", i), PADDR, rr_gnt[i][1] ? 32'h44 : 32'h40);
        end
        S0_PSEL = 0; S1_PSEL = 0;

        // S0 write, PREADY tied high: two downstream cycles, ready at N+2
        cyc();
        S0_PSEL = 1; S0_PENABLE = 0; S0_PWRITE = 1; S0_PADDR = 32'h10;
        S0_PWDATA = 32'hA5A5A5A5; S0_PSTRB = 4'h6; S0_PPROT = 3'h5;
        #1;
        check("wr_n_psel", PSEL, 0);
        cyc(); S0_PENABLE = 1; #1;
        check("wr_setup_ctl",  {PSEL, PENABLE, PWRITE}, 3'b101);
        check("wr_setup_gnt",  GNT, 2'b01);
        check("wr_setup_addr", PADDR, 32'h10);
        check("wr_setup_data", PWDATA, 32'hA5A5A5A5);
        check("wr_setup_sp",   {PSTRB, PPROT}, {4'h6, 3'h5});
        check("wr_setup_rdy",  S0_PREADY, 0);
        cyc(); #1;
        check("wr_acc_ctl", {PSEL, PENABLE}, 2'b11);
        check("wr_acc_rdy", {S0_PREADY, S0_PSLVERR, S1_PREADY}, 3'b100);
        cyc(); S0_PSEL = 0; S0_PENABLE = 0; #1;
        check("wr_done_psel", PSEL, 0);
        check("wr_done_gnt",  GNT, 0);
        check("wr_hold_addr", PADDR, 32'h10);
        check("wr_hold_data", PWDATA, 32'hA5A5A5A5);
        check("wr_mem",       mem[8'h10], 32'hA5A5A5A5);

        // S0 write with slave error: PSLVERR reaches S0 only on the completion cycle
        PSLVERR = 1'b1;
        cyc();
        S0_PSEL = 1; S0_PWRITE = 1; S0_PADDR = 32'h14; S0_PWDATA = 32'h11112222;
        #1;
        cyc(); S0_PENABLE = 1; #1;
        check("err_setup", S0_PSLVERR, 0);
        cyc(); #1;
        check("err_acc", {S0_PREADY, S0_PSLVERR}, 2'b11);
        cyc(); S0_PSEL = 0; S0_PENABLE = 0; #1;
        check("err_after", {S0_PREADY, S0_PSLVERR}, 2'b00);
        PSLVERR = 1'b0;

        // S1 read with three wait states; PREADY arrives on the timeout cycle
        PREADY = 1'b0; PRDATA = 32'h12345678;
        cyc();
        S1_PSEL = 1; S1_PENABLE = 0; S1_PWRITE = 0; S1_PADDR = 32'h20;
        #1;
        cyc(); S1_PENABLE = 1; #1;
        check("rd_setup_gnt", GNT, 2'b10);
        check("rd_setup_ctl", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 32'h20});
        for (int w = 0; w < 3; w++) begin
            cyc(); #1;
            check($sformatf("rd_wait%0d", w), {PENABLE, S1_PREADY, S0_PREADY}, 3'b100);
        end
        cyc(); PREADY = 1'b1; #1;
        check("rd_rdy",   {S1_PREADY, S1_PSLVERR}, 2'b10);
        check("rd_data",  S1_PRDATA, 32'h12345678);
        check("rd_s0",    {S0_PREADY, S0_PSLVERR, S0_PRDATA}, 0);
        cyc(); S1_PSEL = 0; S1_PENABLE = 0; PREADY = 1'b0; #1;
        check("rd_after", {PSEL, S1_PREADY, GNT}, 0);

        // Timeout: PREADY never comes, error returned after 4 ACCESS cycles
        PRDATA = 32'hDEADBEEF;
        cyc();
        S0_PSEL = 1; S0_PENABLE = 0; S0_PWRITE = 0; S0_PADDR = 32'h30;
        #1;
        cyc(); S0_PENABLE = 1; #1;
        for (int w = 0; w < 3; w++) begin
            cyc(); #1;
            check($sformatf("to_wait%0d", w), {PENABLE, S0_PREADY}, 2'b10);
        end
        cyc(); #1;
        check("to_rsp",   {S0_PREADY, S0_PSLVERR}, 2'b11);
        check("to_rdata", S0_PRDATA, 0);
        check("to_psel",  PSEL, 1);
        cyc(); S0_PSEL = 0; S0_PENABLE = 0; #1;
        check("to_after", {PSEL, PENABLE, GNT, S0_PREADY}, 0);

        // Reset during ACCESS abandons the transfer; S1 then completes
        cyc();
        S0_PSEL = 1; S0_PENABLE = 0; S0_PWRITE = 1; S0_PADDR = 32'h50;
        #1;
        cyc(); S0_PENABLE = 1; #1;
        cyc(); #1;
        check("rr_acc_en", PENABLE, 1);
        cyc(); HRESET = 1'b1; PREADY = 1'b1; #1;
        check("rst_mid_rdy", {S0_PREADY, S1_PREADY}, 0);
        check("rst_mid_psel", PSEL, 0);
        cyc();
        HRESET = 1'b0; S0_PSEL = 0; S0_PENABLE = 0;
        S1_PSEL = 1; S1_PENABLE = 0; S1_PWRITE = 0; S1_PADDR = 32'h24;
        PRDATA = 32'h0BADF00D;
        #1;
        check("rst_post_ctl", {PSEL, PENABLE, GNT}, 0);
        check("rst_post_rdy", {S0_PREADY, S1_PREADY}, 0);
        check("rst_post_addr", PADDR, 0);
        // requester drops PSEL after the grant; transfer still completes
        cyc(); S1_PSEL = 0; #1;
        check("post_setup", {GNT, PSEL, PENABLE, PADDR}, {2'b10, 2'b10, 32'h24});
        cyc(); #1;
        check("post_rdy",  {S1_PREADY, S1_PSLVERR, S0_PREADY}, 3'b100);
        check("post_data", S1_PRDATA, 32'h0BADF00D);
        cyc(); PREADY = 1'b0; #1;
        check("post_idle", {PSEL, GNT, S1_PREADY}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
